// File: rtl/alu_result_bcd_display.sv
// Binary-to-BCD seven-segment display stage behind the ALU.
// Iterative double-dabble conversion with leading-zero blanking and sign.
module alu_result_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_in_valid,
    output logic                      io_in_ready,
    input  logic [WIDTH-1:0]          io_in_bits_value,
    input  logic                      io_in_bits_signed,
    output logic                      io_busy,
    output logic                      io_out_valid,
    output logic [7*(DIGITS+1)-1:0]   io_seg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * (DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_nxt;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_nxt;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            neg;
    logic            neg_nxt;
    logic [SW-1:0]   seg_nxt;
    logic            vld_nxt;
    logic            take;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        unique case (d)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digits below the first nonzero one are shown; digit 0 always is.
    function automatic logic [SW-1:0] render(
        input logic [BW-1:0] b,
        input logic          n
    );
        logic [SW-1:0] r;
        logic          seen;
        r    = '1;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (b[4*k +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (seen || k == 0) begin
                r[7*k +: 7] = enc(b[4*k +: 4]);
            end
        end
        r[7*DIGITS +: 7] = n ? 7'h3F : 7'h7F;
        return r;
    endfunction

    assign io_in_ready = (state == IDLE) && !reset;
    assign io_busy     = (state != IDLE);
    assign take        = io_in_valid && io_in_ready;

    // Add-3 correction on every nibble of five or more before shifting.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath updates for the conversion sequence.
    always_comb begin
        state_nxt = state;
        mag_nxt   = mag;
        bcd_nxt   = bcd;
        cnt_nxt   = cnt;
        neg_nxt   = neg;
        seg_nxt   = io_seg;
        vld_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    neg_nxt   = io_in_bits_signed
                              && io_in_bits_value[WIDTH-1];
                    mag_nxt   = neg_nxt
                              ? (~io_in_bits_value) + WIDTH'(1)
                              : io_in_bits_value;
                    bcd_nxt   = '0;
                    cnt_nxt   = CW'(WIDTH);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt = {bcd_adj[BW-2:0], mag[WIDTH-1]};
                mag_nxt = {mag[WIDTH-2:0], 1'b0};
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                seg_nxt   = render(bcd, neg);
                vld_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mag          <= '0;
            bcd          <= '0;
            cnt          <= '0;
            neg          <= 1'b0;
            io_seg       <= '1;
            io_out_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            mag          <= mag_nxt;
            bcd          <= bcd_nxt;
            cnt          <= cnt_nxt;
            neg          <= neg_nxt;
            io_seg       <= seg_nxt;
            io_out_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// Scoreboard bench for alu_result_bcd_display.
// Decimal reference model, randomized and directed stimulus.
module tb_alu_result_bcd_display;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int SW = 7 * (D + 1);

    typedef struct {
        logic [SW-1:0] seg;
        int            cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [W-1:0]  io_in_bits_value = '0;
    logic          io_in_bits_signed = 1'b0;
    logic          io_busy;
    logic          io_out_valid;
    logic [SW-1:0] io_seg;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            remaining = 0;
    bit            pulse_exp = 1'b0;
    bit            acc_flag = 1'b0;
    logic [SW-1:0] disp_exp = '1;

    alu_result_bcd_display #(.WIDTH(W), .DIGITS(D)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_value  (io_in_bits_value),
        .io_in_bits_signed (io_in_bits_signed),
        .io_busy           (io_busy),
        .io_out_valid      (io_out_valid),
        .io_seg            (io_seg)
    );

    always #5 clock = ~clock;

    function automatic logic [SW-1:0] ref_seg(
        input logic [W-1:0] v,
        input logic         s
    );
        logic [6:0]    tbl[10];
        logic [SW-1:0] r;
        bit            neg;
        int            mag;
        int            p;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        neg = s && v[W-1];
        mag = neg ? (1 << W) - int'(v) : int'(v);
        r = '1;
        p = 1;
        for (int k = 0; k < D; k++) begin
            if (k == 0 || mag >= p) begin
                r[7*k +: 7] = tbl[(mag / p) % 10];
            end
            p = p * 10;
        end
        r[7*D +: 7] = neg ? 7'h3F : 7'h7F;
        return r;
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Timing model: a conversion keeps the block busy for W+1 cycles.
    always @(posedge clock) begin
        cyc++;
        pulse_exp = 1'b0;
        if (reset) begin
            remaining = 0;
            sb.delete();
            disp_exp = '1;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) pulse_exp = 1'b1;
        end else if (acc_flag) begin
            remaining = W + 1;
        end
    end

    // Acceptance detector: pushes the reference result on a handshake.
    always @(negedge clock) begin
        #1;
        acc_flag = io_in_valid && io_in_ready;
        if (acc_flag) begin
            sb.push_back('{ref_seg(io_in_bits_value, io_in_bits_signed),
                           cyc + 1});
        end
    end

    // Monitor: pops on each output pulse and checks the handshake signals.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (cyc >= 1) begin
            if (io_out_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got 1, expected 0");
                end else begin
                    e = sb.pop_front();
                    disp_exp = e.seg;
                    chk("latency", cyc - e.cyc, W + 1);
                end
            end
            chk("out_valid", io_out_valid, pulse_exp);
            chk("busy", io_busy, remaining > 0);
            chk("ready", io_in_ready, (remaining == 0) && !reset);
            chk("seg", io_seg, disp_exp);
        end
    end

    task automatic send(input logic [W-1:0] v, input logic s);
        int n;
        n = 0;
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_bits_value = v;
        io_in_bits_signed = s;
        @(posedge clock);
        while (!acc_flag && n < 40) begin
            n++;
            @(posedge clock);
        end
        if (!acc_flag) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ready 0, expected 1");
        end
        @(negedge clock);
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || remaining != 0) && n < 100) begin
            n++;
            @(negedge clock);
        end
        n_cmp++;
        if (sb.size() != 0 || remaining != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        send(8'd0, 1'b0);
        drain();
        send(8'd255, 1'b0);
        drain();
        send(8'h80, 1'b1);
        drain();
        send(8'hF6, 1'b1);
        drain();
        send(8'hF6, 1'b0);
        drain();
        send(8'd9, 1'b1);
        drain();

        // Valid stays high with changing values during a conversion of 42.
        send(8'd42, 1'b0);
        io_in_valid = 1'b1;
        repeat (12) begin
            io_in_bits_value = W'($urandom);
            io_in_bits_signed = 1'($urandom);
            @(negedge clock);
        end
        io_in_valid = 1'b0;
        drain();

        // Reset during the fourth SHIFT cycle of 99 after showing 7.
        send(8'd7, 1'b0);
        drain();
        send(8'd99, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("seg_after_reset", io_seg, {SW{1'b1}});
        send(8'd123, 1'b0);
        drain();

        // Random traffic with random valid and values.
        repeat (300) begin
            io_in_valid = 1'($urandom_range(0, 1));
            io_in_bits_value = W'($urandom);
            io_in_bits_signed = 1'($urandom);
            @(negedge clock);
        end
        io_in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_bcd_display.md
Name: alu_result_bcd_display

Overview:
- Sequential binary-to-decimal display stage placed directly downstream of the ALU.
- Accepts one ALU result per valid/ready handshake and converts it to BCD using an iterative double-dabble (shift-add-3) algorithm.
- Drives DIGITS+1 active-low seven-segment outputs: decimal digits with leading-zero blanking, plus a fixed minus-sign position.
- Replaces the current direct %10 and /10 combinational split, so results of any WIDTH display correctly in signed or unsigned form.

Parameters:
- WIDTH, 8: ALU result width in bits; must be at least 2.
- DIGITS, 3: number of decimal digit positions; must be at least ceil(log10(2^WIDTH)), so WIDTH=8 requires 3.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  a result is presented on the input.
- io_in_ready  output  1  the block can accept a result this cycle.
- io_in_bits_value  input  WIDTH  ALU result.
- io_in_bits_signed  input  1  1 means interpret the value as two's complement; 0 means unsigned.
- io_busy  output  1  a conversion is in progress.
- io_out_valid  output  1  one-cycle pulse when the display registers update.
- io_seg  output  7*(DIGITS+1)  segment codes. Digit k occupies bits [7k+6:7k]; digit 0 is the least significant; digit DIGITS is the sign position.

Behaviour:
- Segment encoding:
  - Within each digit, bit0=a through bit6=g; active-low.
  - Blank = 7'h7F; minus = 7'h3F (only g lit).
  - Digits 0-9 = 40,79,24,30,19,12,02,78,00,10 (hex).
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values:
  - io_seg = all 7'h7F.
  - io_out_valid = 0, io_busy = 0.
  - Internal BCD register cleared; shift counter = 0.
- io_in_ready:
  - Equals (state==IDLE) && !reset. It is 0 in every cycle where reset is high.
- IDLE:
  - A transfer happens when io_in_valid && io_in_ready at a rising edge.
  - On transfer: latch neg = signed && value[WIDTH-1].
  - Latch magnitude = neg ? (~value+1) : value, as an unsigned WIDTH-bit value. The most negative value yields 2^(WIDTH-1) and this is correct.
  - Clear the BCD register (4*DIGITS bits), load counter = WIDTH, go to SHIFT.
  - io_busy is 1 from the next cycle.
- SHIFT, one iteration per cycle:
  - For every BCD nibble >= 5, add 3.
  - Then shift {bcd, magnitude} left by 1.
  - Decrement the counter. When the counter reaches 0 after an iteration, go to DONE.
  - Exactly WIDTH cycles are spent in SHIFT.
- DONE, one cycle:
  - Register io_seg from the final BCD value and neg.
  - Pulse io_out_valid=1 for exactly this cycle, then return to IDLE. io_busy=1 in DONE.
- Latency:
  - Handshake accepted at edge E0; io_out_valid is high during the cycle after edge E0+WIDTH+1.
  - io_in_ready returns to 1 the following cycle.
  - Maximum throughput is one result per WIDTH+2 cycles.
- Leading-zero blanking:
  - Digits above the most significant nonzero digit show 7'h7F.
  - Value 0 shows digit 0 as "0" (7'h40) with all higher digits blank.
- Sign position:
  - Shows 7'h3F when neg=1, otherwise 7'h7F.
  - Unsigned mode never shows a minus.
- Display hold: io_seg keeps the previous result from the end of DONE until the next DONE. It is not blanked during conversion.
- Input handling:
  - io_in_valid while busy is ignored. No queuing; the input value may change freely.
  - Input values are sampled only at the accepting edge.
- Reset mid-conversion: abandon immediately, return to the reset values above, and produce no io_out_valid pulse.

Test Plan:
- Reset held 2 cycles, then released -> io_seg = all 7'h7F, io_out_valid=0, io_in_ready=0 during reset, io_in_ready=1 on the first cycle after.
- Unsigned 8'd0 -> seg0=40, seg1=7F, seg2=7F, seg3=7F; io_out_valid pulses exactly 10 cycles after the accepting edge.
- Unsigned 8'd255 -> seg0=12, seg1=12, seg2=24, seg3=7F; io_busy=1 for 9 cycles; io_in_ready=0 throughout.
- Signed 8'h80 -> seg0=00 (8), seg1=24 (2), seg2=79 (1), seg3=3F (minus). Signed 8'hF6 -> seg0=40, seg1=79, seg2=7F, seg3=3F.
- io_in_valid held high with changing values during a conversion of 8'd42 -> only 42 is displayed (seg0=24, seg1=19); the next value is accepted only when io_in_ready=1.
- Reset asserted in the 4th SHIFT cycle of 8'd99 after a prior display of 7 -> no io_out_valid pulse, io_seg = all 7F, FSM back in IDLE accepting new input.
